// File: rtl/bernoulli_sampler_if.sv
// Request/response bundle between the sigmoid stage and the Bernoulli sampler.
// The master drives probabilities and accepts results; the slave is the sampler.
interface bernoulli_sampler_if #(
  parameter int bitlength = 8,
  parameter int SAMPLES   = 4
) ();
  localparam int CNT_W = $clog2(SAMPLES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [bitlength-1:0] prob;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_bit;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output in_valid, prob, out_ready,
    input  in_ready, out_valid, out_bit, out_count
  );

  modport slave (
    input  in_valid, prob, out_ready,
    output in_ready, out_valid, out_bit, out_count
  );
endinterface

// File: rtl/bernoulli_sampler.sv
// Bernoulli sampler: turns an 8-bit probability (0x80 = 1.0) into SAMPLES
// binary draws against a 16-bit Galois LFSR. The first draw is the unit
// state; the count of ones supports mean-field estimates.
// Optional feature macro: SAMPLER_SEED_LOAD_EN (adds seed_load/seed ports
// for reseeding the LFSR at run time).
// bitlength must be at least 8; only prob[7:0] is compared, higher bits
// saturate the probability to 1.0.
module bernoulli_sampler #(
  parameter int          bitlength = 8,
  parameter int          SAMPLES   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SAMPLER_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [15:0]       seed,
`endif
  bernoulli_sampler_if.slave bus
);

  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t           state_reg;
  logic [15:0]      lfsr_reg;
  logic [7:0]       p_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             bit_reg;
  logic [CNT_W-1:0] count_reg;

  logic             prob_hi;
  logic [7:0]       p_capture;
  logic             draw_bit;
  logic [15:0]      lfsr_next;

  // Saturate the incoming probability to 0x80 so the 7-bit random value
  // always wins at 1.0; any bit above bit 7 also means "certain".
  assign prob_hi   = |(bus.prob >> 8);
  assign p_capture = (prob_hi || (bus.prob[7:0] >= 8'h80)) ? 8'h80 : bus.prob[7:0];

  // One draw: 7-bit random value against the captured threshold.
  assign draw_bit  = ({1'b0, lfsr_reg[6:0]} < p_reg);

  // Right-shifting Galois step, taps 0xB400.
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

  // Handshake flags come straight from the state register.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_bit   = bit_reg;
  assign bus.out_count = count_reg;

  // Control FSM, LFSR and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lfsr_reg  <= LFSR_SEED;
      p_reg     <= 8'h00;
      idx_reg   <= '0;
      bit_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      // The LFSR only moves while drawing, so a stalled result keeps the
      // random stream where it was. A seed load overrides that advance,
      // but the draw in the same cycle still used the old low bits.
`ifdef SAMPLER_SEED_LOAD_EN
      if (seed_load) begin
        lfsr_reg <= (seed == 16'h0000) ? LFSR_SEED : seed;
      end else if (state_reg == DRAW) begin
        lfsr_reg <= lfsr_next;
      end
`else
      if (state_reg == DRAW) begin
        lfsr_reg <= lfsr_next;
      end
`endif

      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            p_reg     <= p_capture;
            count_reg <= '0;
            idx_reg   <= '0;
            state_reg <= DRAW;
          end
        end
        DRAW: begin
          if (idx_reg == '0) begin
            bit_reg <= draw_bit;
          end
          count_reg <= count_reg + CNT_W'(draw_bit);
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          // Consuming the result never overlaps with accepting a new one:
          // IDLE must be visited for at least one cycle.
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bernoulli_sampler.sv
// Directed bench for bernoulli_sampler: one instance with SAMPLES=1 and one
// with SAMPLES=4, sharing clock and reset. Expected values are hand-derived
// from the LFSR sequence ACE1 -> E270 -> 7138 -> 389C -> 1C4E.
module tb_bernoulli_sampler;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

`ifdef SAMPLER_SEED_LOAD_EN
  logic        seed_load;
  logic [15:0] seed;
`endif

  bernoulli_sampler_if #(.bitlength(8), .SAMPLES(1)) bus1 ();
  bernoulli_sampler_if #(.bitlength(8), .SAMPLES(4)) bus4 ();

  bernoulli_sampler #(.bitlength(8), .SAMPLES(1), .LFSR_SEED(16'hACE1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SAMPLER_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .bus       (bus1)
  );

  bernoulli_sampler #(.bitlength(8), .SAMPLES(4), .LFSR_SEED(16'hACE1)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SAMPLER_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .bus       (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic req1(input logic [7:0] p, output logic b, output logic c);
    int n;
    n = 0;
    while (!bus1.in_ready && n < 50) begin step(); n++; end
    if (!bus1.in_ready) chk("req1_in_ready_timeout", 32'd0, 32'd1);
    bus1.prob = p;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 50) begin step(); n++; end
    if (!bus1.out_valid) chk("req1_out_valid_timeout", 32'd0, 32'd1);
    b = bus1.out_bit;
    c = bus1.out_count;
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
  endtask

  task automatic req4(input logic [7:0] p, output logic b, output logic [2:0] c);
    int n;
    n = 0;
    while (!bus4.in_ready && n < 50) begin step(); n++; end
    if (!bus4.in_ready) chk("req4_in_ready_timeout", 32'd0, 32'd1);
    bus4.prob = p;
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    n = 0;
    while (!bus4.out_valid && n < 50) begin step(); n++; end
    if (!bus4.out_valid) chk("req4_out_valid_timeout", 32'd0, 32'd1);
    b = bus4.out_bit;
    c = bus4.out_count;
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    logic       b1;
    logic       c1;
    logic       b4;
    logic [2:0] c4;

    total = 0;
    bad   = 0;
    bus1.prob = 8'h00;
    bus4.prob = 8'h00;
`ifdef SAMPLER_SEED_LOAD_EN
    seed_load = 1'b0;
    seed      = 16'h0000;
`endif

    // Reset state
    do_reset();
    chk("rst_in_ready4",  32'(bus4.in_ready),  32'd1);
    chk("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
    chk("rst_out_bit4",   32'(bus4.out_bit),   32'd0);
    chk("rst_out_count4", 32'(bus4.out_count), 32'd0);
    chk("rst_lfsr4",      32'(u_dut4.lfsr_reg), 32'h0000ACE1);
    chk("rst_in_ready1",  32'(bus1.in_ready),  32'd1);
    chk("rst_out_valid1", 32'(bus1.out_valid), 32'd0);

    // Threshold pass: r=97 < 98
    req1(8'h62, b1, c1);
    chk("thr_pass_bit",   32'(b1), 32'd1);
    chk("thr_pass_count", 32'(c1), 32'd1);
    chk("thr_pass_lfsr",  32'(u_dut1.lfsr_reg), 32'h0000E270);

    // Threshold fail: r=97 < 97 is false
    do_reset();
    req1(8'h61, b1, c1);
    chk("thr_fail_bit",   32'(b1), 32'd0);
    chk("thr_fail_count", 32'(c1), 32'd0);

    // Four draws at p=98: r = 97,112,56,28 -> 1,0,1,1
    req4(8'h62, b4, c4);
    chk("p62_bit",   32'(b4), 32'd1);
    chk("p62_count", 32'(c4), 32'd3);
    chk("p62_lfsr",  32'(u_dut4.lfsr_reg), 32'h00001C4E);

    // Saturation
    req4(8'h80, b4, c4);
    chk("p80_bit",   32'(b4), 32'd1);
    chk("p80_count", 32'(c4), 32'd4);
    req4(8'hFF, b4, c4);
    chk("pFF_bit",   32'(b4), 32'd1);
    chk("pFF_count", 32'(c4), 32'd4);
    req4(8'h00, b4, c4);
    chk("p00_bit",   32'(b4), 32'd0);
    chk("p00_count", 32'(c4), 32'd0);

    // Handshake, latency, ignored inputs and backpressure
    do_reset();
    bus4.prob = 8'h62;
    bus4.in_valid = 1'b1;
    step();                       // edge T: accepted
    bus4.prob = 8'h00;            // must be ignored while busy
    chk("lat_T_in_ready",  32'(bus4.in_ready),  32'd0);
    chk("lat_T_out_valid", 32'(bus4.out_valid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("lat_T%0d_out_valid", k), 32'(bus4.out_valid), 32'd0);
      chk($sformatf("lat_T%0d_in_ready", k),  32'(bus4.in_ready),  32'd0);
    end
    step();                       // edge T+4
    chk("lat_T4_out_valid", 32'(bus4.out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("hold%0d_valid", k), 32'(bus4.out_valid), 32'd1);
      chk($sformatf("hold%0d_bit", k),   32'(bus4.out_bit),   32'd1);
      chk($sformatf("hold%0d_count", k), 32'(bus4.out_count), 32'd3);
      chk($sformatf("hold%0d_lfsr", k),  32'(u_dut4.lfsr_reg), 32'h00001C4E);
    end
    bus4.out_ready = 1'b1;        // in_valid still high: no same-cycle accept
    step();
    chk("consume_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("consume_in_ready",  32'(bus4.in_ready),  32'd1);
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;

    // Reset mid-DRAW after two draws
    do_reset();
    bus4.prob = 8'h62;
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    step();
    step();
    chk("mid_draw_bit_set", 32'(bus4.out_bit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bit",       32'(bus4.out_bit),    32'd0);
    chk("mid_rst_count",     32'(bus4.out_count),  32'd0);
    chk("mid_rst_in_ready",  32'(bus4.in_ready),   32'd1);
    chk("mid_rst_out_valid", 32'(bus4.out_valid),  32'd0);
    chk("mid_rst_lfsr",      32'(u_dut4.lfsr_reg), 32'h0000ACE1);
    #2 rst_n = 1'b1;
    step();
    req4(8'h62, b4, c4);
    chk("rerun_bit",   32'(b4), 32'd1);
    chk("rerun_count", 32'(c4), 32'd3);

`ifdef SAMPLER_SEED_LOAD_EN
    // Seed load: zero falls back to the reset seed, nonzero is taken as is
    req1(8'h62, b1, c1);
    chk("seed_pre_lfsr", 32'(u_dut1.lfsr_reg), 32'h0000E270);
    seed = 16'h0000;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk("seed_zero_lfsr", 32'(u_dut1.lfsr_reg), 32'h0000ACE1);
    seed = 16'h0005;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk("seed_5_lfsr", 32'(u_dut1.lfsr_reg), 32'h00000005);
    req1(8'h06, b1, c1);
    chk("seed_5_bit",   32'(b1), 32'd1);
    chk("seed_5_count", 32'(c1), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
